sync_hs_tx: RTL and testbench
=============================

# sync_hs_tx

Source-side transmitter for a two-phase (toggle) bundled-data clock-domain crossing. It accepts words on a valid/ready port and launches each one as a held data bus plus a toggled request level. It then waits for the far-end receiver's acknowledge toggle, which it brings in through an internal three-stage synchronizer, and completes the transfer. It sits in the source clock domain, pairs with the destination-side synchronizing receiver, and is the only driver of the crossing's request and data wires.

## Interface
- DW, 32, width of the transferred payload.
- clk  input  1  source-domain clock.
- reset_  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- in_pvld  input  1  source word valid.
- in_prdy  output  1  transmitter can accept a word this cycle.
- in_pd  input  DW  source payload.
- tx_req  output  1  request level to destination; toggles once per launched word; driven directly from a flop.
- tx_pd  output  DW  payload to destination; flop-driven; stable whenever a transfer is outstanding.
- ack_async  input  1  acknowledge toggle from the destination domain; asynchronous to clk.
- tx_busy  output  1  a transfer is outstanding (state WAIT).
- ack_err  output  1  sticky: acknowledge toggled while no transfer was outstanding.

## Operation
- ack_async passes through three flops (s1→s2→s3), each reset to 0. Only s3 (ack_s) is used.
- Completion condition is ack_s == tx_req while in WAIT.
- The FSM has two states, IDLE and WAIT; reset state is IDLE.
- Launch: tx_pd <= word, tx_req <= ~tx_req, state <= WAIT.
- IDLE: when in_pvld & in_prdy, launch in_pd.
- WAIT, not complete: hold tx_req and tx_pd; never change either.
- WAIT, complete: return to IDLE, unless a queued word exists under SYNC_HS_TX_SKID_EN.
- Without the skid, in_prdy = (state == IDLE). in_prdy is derived from state flops only, not from in_pvld.
- ack_err is set when state == IDLE and ack_s != tx_req. It remains set until reset. Protocol state is unaffected: the transmitter ignores the mismatch and the next launch proceeds normally.
- tx_busy = (state == WAIT).
- Reset mid-transfer: all flops return to reset values immediately and asynchronously. The pending word is dropped. The destination must be reset in the same reset domain.

## Timing
- Reset values: tx_req=0, tx_pd=0, tx_busy=0, ack_err=0, in_prdy=1, all synchronizer flops 0.
- Accept at edge T: tx_req toggles and tx_pd is valid after edge T; tx_busy=1 from T.
- Suppose ack_async changes before edge A. ack_s reflects it after edge A+2, giving 3-cycle synchronizer latency.
- Completion is evaluated in the cycle after edge A+2 and takes effect at edge A+3. in_prdy rises after A+3 (no skid).
- Minimum spacing between successive tx_req toggles is therefore round-trip latency plus 1 cycle.
- tx_pd changes only on the same edge as a tx_req toggle.

## Configuration
- SYNC_HS_TX_SKID_EN: adds a one-entry skid register (skid_vld, skid_pd).
  - in_prdy = ~skid_vld.
  - In WAIT and not completing, an accepted word goes to the skid.
  - On completion with skid_vld=1, the skid word launches on the same edge, skid_vld clears, and the state stays WAIT.
  - On completion with skid empty, a word accepted that cycle launches directly and the state stays WAIT.
  - In IDLE, accepted words launch directly.
- Without the macro: no skid flops; in_prdy = (state == IDLE).

## Test plan
- Single transfer: reset, in_pd=32'hA5A5_0001 with pvld for 1 cycle, ack loopback delayed 2 cycles → tx_req 0→1 one edge after accept; tx_pd=32'hA5A5_0001 held; in_prdy=0 until 3 edges after ack change, then 1.
- Back-to-back stream: 8 words 0..7 with pvld held high, loopback ack → tx_pd sequence 0..7 in order, 8 tx_req toggles, tx_pd never changes while tx_busy=1 and ack_s≠tx_req.
- Skid (macro on): launch word 1, present word 2 during WAIT → in_prdy drops after accept; on ack, word 2 launches on the completion edge with no IDLE cycle; tx_busy stays 1.
- Spurious ack: in IDLE, toggle ack_async → ack_err=1 three edges later and stays 1; a following transfer still completes normally.
- Reset mid-transfer: assert reset_ while tx_busy=1 → tx_req, tx_pd, tx_busy return to 0 asynchronously and in_prdy=1; the first transfer after release behaves as in the single-transfer scenario.
- Ack timing: ack_async toggled asynchronously at randomized phases → no completion is observed before 3 clk edges, and none is missed.

Source files
------------

// File: rtl/sync_hs_tx.sv
// Source side of a two-phase bundled-data crossing: launches words as a held bus plus request toggle.
// Optional macro SYNC_HS_TX_SKID_EN adds a one-entry skid so a word can queue while a transfer is in flight.
module sync_hs_tx #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic          in_pvld,
  output logic          in_prdy,
  input  logic [DW-1:0] in_pd,
  output logic          tx_req,
  output logic [DW-1:0] tx_pd,
  input  logic          ack_async,
  output logic          tx_busy,
  output logic          ack_err
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

  state_e        state_q, state_d;
  logic          tx_req_q, tx_req_d;
  logic [DW-1:0] tx_pd_q, tx_pd_d;
  logic          ack_err_q, ack_err_d;
  logic          ack_s1_q, ack_s2_q, ack_s3_q;
  logic          accept;
  logic          complete;

`ifdef SYNC_HS_TX_SKID_EN
  logic          skid_vld_q, skid_vld_d;
  logic [DW-1:0] skid_pd_q, skid_pd_d;
  assign in_prdy = ~skid_vld_q;
`else
  assign in_prdy = (state_q == IDLE);
`endif

  assign accept   = in_pvld & in_prdy;
  // The far end has echoed our current request level: the word has been taken.
  assign complete = (state_q == WAIT) && (ack_s3_q == tx_req_q);

  always_comb begin
    state_d   = state_q;
    tx_req_d  = tx_req_q;
    tx_pd_d   = tx_pd_q;
    ack_err_d = ack_err_q | ((state_q == IDLE) && (ack_s3_q != tx_req_q));
`ifdef SYNC_HS_TX_SKID_EN
    skid_vld_d = skid_vld_q;
    skid_pd_d  = skid_pd_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          tx_pd_d  = in_pd;
          tx_req_d = ~tx_req_q;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (complete) begin
`ifdef SYNC_HS_TX_SKID_EN
          if (skid_vld_q) begin
            tx_pd_d    = skid_pd_q;
            tx_req_d   = ~tx_req_q;
            skid_vld_d = 1'b0;
          end else if (accept) begin
            tx_pd_d  = in_pd;
            tx_req_d = ~tx_req_q;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
`ifdef SYNC_HS_TX_SKID_EN
        else if (accept) begin
          skid_vld_d = 1'b1;
          skid_pd_d  = in_pd;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q   <= IDLE;
      tx_req_q  <= 1'b0;
      tx_pd_q   <= '0;
      ack_err_q <= 1'b0;
      ack_s1_q  <= 1'b0;
      ack_s2_q  <= 1'b0;
      ack_s3_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_req_q  <= tx_req_d;
      tx_pd_q   <= tx_pd_d;
      ack_err_q <= ack_err_d;
      ack_s1_q  <= ack_async;
      ack_s2_q  <= ack_s1_q;
      ack_s3_q  <= ack_s2_q;
    end
  end

`ifdef SYNC_HS_TX_SKID_EN
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      skid_vld_q <= 1'b0;
      skid_pd_q  <= '0;
    end else begin
      skid_vld_q <= skid_vld_d;
      skid_pd_q  <= skid_pd_d;
    end
  end
`endif

  assign tx_req  = tx_req_q;
  assign tx_pd   = tx_pd_q;
  assign tx_busy = (state_q == WAIT);
  assign ack_err = ack_err_q;

endmodule

// File: tb/tb_sync_hs_tx.sv
// Directed bench for sync_hs_tx; inputs change and outputs are sampled on the falling clock edge.
module tb_sync_hs_tx;
  localparam int DW = 32;
`ifdef SYNC_HS_TX_SKID_EN
  localparam logic SKID = 1'b1;
  localparam int SPACING = 6;
`else
  localparam logic SKID = 1'b0;
  localparam int SPACING = 7;
`endif

  logic          clk = 1'b0;
  logic          reset_ = 1'b0;
  logic          in_pvld = 1'b0;
  logic          in_prdy;
  logic [DW-1:0] in_pd = '0;
  logic          tx_req;
  logic [DW-1:0] tx_pd;
  logic          ack_async = 1'b0;
  logic          tx_busy;
  logic          ack_err;

  int   checks = 0;
  int   errors = 0;
  logic lb_en = 1'b0;
  logic [3:0] lb_hist = '0;
  logic exp_req = 1'b0;

  always #5 clk = ~clk;

  sync_hs_tx #(.DW(DW)) dut (
    .clk(clk), .reset_(reset_), .in_pvld(in_pvld), .in_prdy(in_prdy), .in_pd(in_pd),
    .tx_req(tx_req), .tx_pd(tx_pd), .ack_async(ack_async), .tx_busy(tx_busy), .ack_err(ack_err)
  );

  // Advance to the next falling edge; optionally loop tx_req back as ack, two samples late.
  task automatic tick();
    @(negedge clk);
    lb_hist = {lb_hist[2:0], tx_req};
    if (lb_en) ack_async = lb_hist[2];
  endtask

  task automatic test_reset();
    reset_ = 1'b0; in_pvld = 1'b0; ack_async = 1'b0;
    #2;
    checks++;
    if ({tx_req, tx_pd, tx_busy, ack_err, in_prdy} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got req=%b pd=%h busy=%b err=%b prdy=%b exp 0 0 0 0 1",
               tx_req, tx_pd, tx_busy, ack_err, in_prdy);
    end
    tick(); tick();
    reset_ = 1'b1;
    exp_req = 1'b0;
    tick();
  endtask

  task automatic do_single(input logic [DW-1:0] w, input string nm);
    in_pd = w; in_pvld = 1'b1;
    tick();
    in_pvld = 1'b0;
    exp_req = ~exp_req;
    checks++;
    if ({tx_req, tx_pd, tx_busy, in_prdy} !== {exp_req, w, 1'b1, SKID}) begin
      errors++;
      $display("FAIL %s_launch got req=%b pd=%h busy=%b prdy=%b exp req=%b pd=%h busy=1 prdy=%b",
               nm, tx_req, tx_pd, tx_busy, in_prdy, exp_req, w, SKID);
    end
    tick(); tick();
    ack_async = exp_req;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({tx_req, tx_pd, tx_busy, in_prdy} !== {exp_req, w, 1'b1, SKID}) begin
        errors++;
        $display("FAIL %s_hold%0d got req=%b pd=%h busy=%b prdy=%b exp req=%b pd=%h busy=1 prdy=%b",
                 nm, i, tx_req, tx_pd, tx_busy, in_prdy, exp_req, w, SKID);
      end
    end
    tick();
    checks++;
    if ({tx_req, tx_pd, tx_busy, in_prdy} !== {exp_req, w, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL %s_done got req=%b pd=%h busy=%b prdy=%b exp req=%b pd=%h busy=0 prdy=1",
               nm, tx_req, tx_pd, tx_busy, in_prdy, exp_req, w);
    end
  endtask

  task automatic test_single();
    do_single(32'hA5A5_0001, "single");
  endtask

  task automatic test_back_to_back();
    int k = 0, nrecv = 0, last = 0;
    logic hand, prev_req;
    logic [DW-1:0] prev_pd;
    bit done = 0;
    lb_en = 1'b1;
    in_pd = 0; in_pvld = 1'b1;
    prev_req = tx_req; prev_pd = tx_pd;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      hand = in_pvld & in_prdy;
      tick();
      if (hand) begin
        k++;
        if (k == 8) in_pvld = 1'b0; else in_pd = k;
      end
      checks++;
      if (tx_req !== prev_req) begin
        if (tx_pd !== nrecv) begin
          errors++;
          $display("FAIL stream_word got=%h exp=%h", tx_pd, nrecv);
        end
        if (nrecv > 0 && (cyc - last) != SPACING) begin
          errors++;
          $display("FAIL stream_spacing got=%0d exp=%0d", cyc - last, SPACING);
        end
        last = cyc;
        nrecv++;
      end else if (tx_pd !== prev_pd) begin
        errors++;
        $display("FAIL stream_pd_stable got=%h exp=%h", tx_pd, prev_pd);
      end
      prev_req = tx_req; prev_pd = tx_pd;
      if (nrecv == 8 && !tx_busy) done = 1;
    end
    checks++;
    if (nrecv != 8 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL stream_count got toggles=%0d busy=%b exp toggles=8 busy=0", nrecv, tx_busy);
    end
    lb_en = 1'b0;
  endtask

`ifdef SYNC_HS_TX_SKID_EN
  task automatic test_skid();
    in_pd = 32'h1; in_pvld = 1'b1;
    tick();
    exp_req = ~exp_req;
    in_pd = 32'h2;
    tick();
    in_pvld = 1'b0;
    checks++;
    if ({in_prdy, tx_pd, tx_req, tx_busy} !== {1'b0, 32'h1, exp_req, 1'b1}) begin
      errors++;
      $display("FAIL skid_fill got prdy=%b pd=%h req=%b busy=%b exp prdy=0 pd=1 req=%b busy=1",
               in_prdy, tx_pd, tx_req, tx_busy, exp_req);
    end
    ack_async = exp_req;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({tx_pd, tx_busy} !== {32'h1, 1'b1}) begin
        errors++;
        $display("FAIL skid_hold%0d got pd=%h busy=%b exp pd=1 busy=1", i, tx_pd, tx_busy);
      end
    end
    tick();
    exp_req = ~exp_req;
    checks++;
    if ({tx_pd, tx_req, tx_busy, in_prdy} !== {32'h2, exp_req, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL skid_launch got pd=%h req=%b busy=%b prdy=%b exp pd=2 req=%b busy=1 prdy=1",
               tx_pd, tx_req, tx_busy, in_prdy, exp_req);
    end
    ack_async = exp_req;
    repeat (4) tick();
    checks++;
    if (tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL skid_done got busy=%b exp 0", tx_busy);
    end
  endtask
`endif

  task automatic test_spurious_ack();
    ack_async = ~exp_req;
    tick(); tick(); tick();
    checks++;
    if (ack_err !== 1'b0) begin
      errors++;
      $display("FAIL spur_early got err=%b exp 0", ack_err);
    end
    tick();
    checks++;
    if ({ack_err, tx_busy, in_prdy, tx_req} !== {1'b1, 1'b0, 1'b1, exp_req}) begin
      errors++;
      $display("FAIL spur_set got err=%b busy=%b prdy=%b req=%b exp err=1 busy=0 prdy=1 req=%b",
               ack_err, tx_busy, in_prdy, tx_req, exp_req);
    end
    ack_async = exp_req;
    repeat (4) tick();
    do_single(32'h0000_BEEF, "spur_next");
    checks++;
    if (ack_err !== 1'b1) begin
      errors++;
      $display("FAIL spur_sticky got err=%b exp 1", ack_err);
    end
  endtask

  task automatic test_ack_timing();
    for (int n = 0; n < 4; n++) begin
      in_pd = 32'hC0DE_0000 + n; in_pvld = 1'b1;
      tick();
      in_pvld = 1'b0;
      exp_req = ~exp_req;
      repeat ($urandom_range(0, 3)) tick();
      #($urandom_range(1, 4));
      ack_async = exp_req;
      for (int i = 0; i < 3; i++) begin
        tick();
        checks++;
        if (tx_busy !== 1'b1) begin
          errors++;
          $display("FAIL ackt_early%0d_%0d got busy=%b exp 1", n, i, tx_busy);
        end
      end
      tick();
      checks++;
      if ({tx_busy, tx_req} !== {1'b0, exp_req}) begin
        errors++;
        $display("FAIL ackt_done%0d got busy=%b req=%b exp busy=0 req=%b", n, tx_busy, tx_req, exp_req);
      end
    end
  endtask

  task automatic test_reset_mid();
    in_pd = 32'h1234_5678; in_pvld = 1'b1;
    tick();
    in_pvld = 1'b0;
    tick();
    checks++;
    if (tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy got=%b exp=1", tx_busy);
    end
    #2 reset_ = 1'b0;
    #1;
    checks++;
    if ({tx_req, tx_pd, tx_busy, in_prdy, ack_err} !== {1'b0, 32'h0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_async got req=%b pd=%h busy=%b prdy=%b err=%b exp 0 0 0 1 0",
               tx_req, tx_pd, tx_busy, in_prdy, ack_err);
    end
    ack_async = 1'b0;
    exp_req = 1'b0;
    tick(); tick();
    reset_ = 1'b1;
    tick();
    do_single(32'hA5A5_0001, "rstmid_after");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
`ifdef SYNC_HS_TX_SKID_EN
    test_skid();
`endif
    test_spurious_ack();
    test_ack_timing();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
